// File: rtl/clocked_demux.sv
// clocked_demux: receive side of the clocked time-multiplexed link.
// Splits an alternating first/second word stream back into parallel
// pos/neg words. A sync marker aligns the pair boundary, and each
// completed pair is presented with a one-cycle pair_valid pulse.
module clocked_demux #(
  parameter int IN_WIDTH    = 30,
  parameter int OUT_WIDTH   = 32,
  parameter bit INVERT      = 1'b1,
  parameter bit SIGN_EXTEND = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  q_in,
  input  logic                 sync_in,
  output logic [OUT_WIDTH-1:0] pos_out,
  output logic [OUT_WIDTH-1:0] neg_out,
  output logic                 pair_valid,
  output logic                 locked,
  output logic                 phase_err,
  output logic [7:0]           err_count
);

  if (OUT_WIDTH < IN_WIDTH) begin : g_width_check
    $error("clocked_demux: OUT_WIDTH must be >= IN_WIDTH");
  end

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  // Widen one received word to the output width. Sign or zero fill
  // depends on SIGN_EXTEND; equal widths pass straight through.
  function automatic logic [OUT_WIDTH-1:0] ext_word(input logic [IN_WIDTH-1:0] w);
    logic signed [IN_WIDTH-1:0] ws;
    logic [OUT_WIDTH-1:0]       r;
    ws = w;
    if (SIGN_EXTEND) r = OUT_WIDTH'(ws);
    else             r = OUT_WIDTH'(w);
    return r;
  endfunction

  state_t                                   state_p0;
  logic                                     phase_p0;
  (* shreg_extract = "no" *) logic [IN_WIDTH-1:0]  hold_p0;
  (* shreg_extract = "no" *) logic [OUT_WIDTH-1:0] pos_p1;
  (* shreg_extract = "no" *) logic [OUT_WIDTH-1:0] neg_p1;
  logic                                     vld_p1;
  logic                                     locked_p1;
  logic                                     perr_p1;
  logic [7:0]                               err_cnt_p1;

  // Stage p0 -> p1: lock/phase tracking, first-word capture, pair emission
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p0   <= UNLOCKED;
      phase_p0   <= 1'b0;
      hold_p0    <= '0;
      pos_p1     <= '0;
      neg_p1     <= '0;
      vld_p1     <= 1'b0;
      locked_p1  <= 1'b0;
      perr_p1    <= 1'b0;
      err_cnt_p1 <= 8'd0;
    end else begin
      vld_p1  <= 1'b0;
      perr_p1 <= 1'b0;
      case (state_p0)
        UNLOCKED: begin
          if (sync_in) begin
            hold_p0   <= q_in;
            phase_p0  <= 1'b1;
            state_p0  <= LOCKED;
            locked_p1 <= 1'b1;
          end
        end
        LOCKED: begin
          if (!phase_p0) begin
            // The marker is optional once locked.
            hold_p0  <= q_in;
            phase_p0 <= 1'b1;
          end else if (sync_in) begin
            // Marker on a second-word slot: drop the pending word and
            // realign on this one as the new first word.
            hold_p0 <= q_in;
            perr_p1 <= 1'b1;
            if (err_cnt_p1 != 8'hFF) err_cnt_p1 <= err_cnt_p1 + 8'd1;
          end else begin
            phase_p0 <= 1'b0;
            vld_p1   <= 1'b1;
            if (INVERT) begin
              pos_p1 <= ext_word(hold_p0);
              neg_p1 <= ext_word(q_in);
            end else begin
              neg_p1 <= ext_word(hold_p0);
              pos_p1 <= ext_word(q_in);
            end
          end
        end
        default: state_p0 <= UNLOCKED;
      endcase
    end
  end

  assign pos_out    = pos_p1;
  assign neg_out    = neg_p1;
  assign pair_valid = vld_p1;
  assign locked     = locked_p1;
  assign phase_err  = perr_p1;
  assign err_count  = err_cnt_p1;

endmodule

// File: tb/tb_clocked_demux.sv
// tb_clocked_demux: directed vector bench for clocked_demux.
// Instance a: INVERT=1, SIGN_EXTEND=1. Instance b: INVERT=0, SIGN_EXTEND=0.
module tb_clocked_demux;

  logic        clock = 1'b0;
  logic        reset;
  logic [29:0] q_a, q_b;
  logic        sync_a, sync_b;
  logic [31:0] pos_a, neg_a, pos_b, neg_b;
  logic        vld_a, lock_a, perr_a, vld_b, lock_b, perr_b;
  logic [7:0]  cnt_a, cnt_b;

  int n_chk  = 0;
  int n_fail = 0;

  clocked_demux #(.IN_WIDTH(30), .OUT_WIDTH(32), .INVERT(1'b1), .SIGN_EXTEND(1'b1)) dut_a (
    .clock(clock), .reset(reset), .q_in(q_a), .sync_in(sync_a),
    .pos_out(pos_a), .neg_out(neg_a), .pair_valid(vld_a), .locked(lock_a),
    .phase_err(perr_a), .err_count(cnt_a)
  );

  clocked_demux #(.IN_WIDTH(30), .OUT_WIDTH(32), .INVERT(1'b0), .SIGN_EXTEND(1'b0)) dut_b (
    .clock(clock), .reset(reset), .q_in(q_b), .sync_in(sync_b),
    .pos_out(pos_b), .neg_out(neg_b), .pair_valid(vld_b), .locked(lock_b),
    .phase_err(perr_b), .err_count(cnt_b)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sync;
    logic [29:0] q;
    logic        vld;
    logic [31:0] pos;
    logic [31:0] neg;
    logic        lock;
    logic        perr;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step_a(input logic s, input logic [29:0] q);
    sync_a = s;
    q_a    = q;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Lock and stream, misaligned-marker realign, full-scale negative pair.
    vecs[0] = '{1'b1, 30'h1000_0001, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 30'h0000_0002, 1'b1, 32'h1000_0001, 32'h0000_0002, 1'b1, 1'b0, 8'd0};
    vecs[2] = '{1'b0, 30'h0000_0003, 1'b0, 32'h1000_0001, 32'h0000_0002, 1'b1, 1'b0, 8'd0};
    vecs[3] = '{1'b0, 30'h2000_0004, 1'b1, 32'h0000_0003, 32'hE000_0004, 1'b1, 1'b0, 8'd0};
    vecs[4] = '{1'b1, 30'h0000_000A, 1'b0, 32'h0000_0003, 32'hE000_0004, 1'b1, 1'b0, 8'd0};
    vecs[5] = '{1'b1, 30'h0000_000B, 1'b0, 32'h0000_0003, 32'hE000_0004, 1'b1, 1'b1, 8'd1};
    vecs[6] = '{1'b0, 30'h0000_000C, 1'b1, 32'h0000_000B, 32'h0000_000C, 1'b1, 1'b0, 8'd1};
    vecs[7] = '{1'b0, 30'h3FFF_FFFF, 1'b0, 32'h0000_000B, 32'h0000_000C, 1'b1, 1'b0, 8'd1};
    vecs[8] = '{1'b0, 30'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 8'd1};

    reset = 1'b1; sync_a = 1'b0; q_a = '0; sync_b = 1'b0; q_b = '0;
    @(posedge clock); @(posedge clock); #1;
    chk("rst_pos",  pos_a,  32'h0);
    chk("rst_neg",  neg_a,  32'h0);
    chk("rst_vld",  vld_a,  32'h0);
    chk("rst_lock", lock_a, 32'h0);
    chk("rst_perr", perr_a, 32'h0);
    chk("rst_cnt",  cnt_a,  32'h0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      step_a(vecs[i].sync, vecs[i].q);
      chk($sformatf("v%0d_vld", i),  vld_a,  vecs[i].vld);
      chk($sformatf("v%0d_pos", i),  pos_a,  vecs[i].pos);
      chk($sformatf("v%0d_neg", i),  neg_a,  vecs[i].neg);
      chk($sformatf("v%0d_lock", i), lock_a, vecs[i].lock);
      chk($sformatf("v%0d_perr", i), perr_a, vecs[i].perr);
      chk($sformatf("v%0d_cnt", i),  cnt_a,  vecs[i].cnt);
    end

    // Saturation: one legal first-word marker then 300 misaligned markers.
    for (int i = 0; i < 301; i++) step_a(1'b1, 30'(i));
    chk("sat_cnt",  cnt_a,  32'd255);
    chk("sat_lock", lock_a, 32'h1);
    chk("sat_perr", perr_a, 32'h1);
    chk("sat_pos",  pos_a,  32'hFFFF_FFFF);
    step_a(1'b1, 30'h1);
    chk("sat_hold", cnt_a,  32'd255);

    // Reset mid-pair, with a marker on the reset edge.
    reset = 1'b1; step_a(1'b0, 30'h0); reset = 1'b0;
    chk("clr_cnt", cnt_a, 32'h0);
    step_a(1'b1, 30'h5);
    chk("mid_lock", lock_a, 32'h1);
    reset = 1'b1; step_a(1'b1, 30'h6); reset = 1'b0;
    chk("mid_lock0", lock_a, 32'h0);
    chk("mid_vld",   vld_a,  32'h0);
    chk("mid_pos",   pos_a,  32'h0);
    chk("mid_neg",   neg_a,  32'h0);
    chk("mid_cnt",   cnt_a,  32'h0);

    // Pre-lock data without a marker is ignored.
    for (int i = 0; i < 10; i++) begin
      step_a(1'b0, 30'h0ABC_0000 + 30'(i));
      chk($sformatf("pre%0d_vld", i),  vld_a,  32'h0);
      chk($sformatf("pre%0d_pos", i),  pos_a,  32'h0);
      chk($sformatf("pre%0d_lock", i), lock_a, 32'h0);
    end
    step_a(1'b1, 30'h7);
    chk("relock_lock", lock_a, 32'h1);
    chk("relock_vld",  vld_a,  32'h0);
    step_a(1'b0, 30'h8);
    chk("relock_vld1", vld_a, 32'h1);
    chk("relock_pos",  pos_a, 32'h7);
    chk("relock_neg",  neg_a, 32'h8);

    // Ordering swap and zero extension on instance b.
    chk("b_prelock", lock_b, 32'h0);
    sync_b = 1'b1; q_b = 30'h2AAA_AAAA;
    @(posedge clock); #1;
    chk("b_lock", lock_b, 32'h1);
    chk("b_vld0", vld_b,  32'h0);
    sync_b = 1'b0; q_b = 30'h1555_5555;
    @(posedge clock); #1;
    chk("b_vld", vld_b, 32'h1);
    chk("b_neg", neg_b, 32'h2AAA_AAAA);
    chk("b_pos", pos_b, 32'h1555_5555);
    q_b = 30'h3000_0001;
    @(posedge clock); #1;
    chk("b_vld_off", vld_b, 32'h0);
    chk("b_hold",    neg_b, 32'h2AAA_AAAA);
    q_b = 30'h0000_0009;
    @(posedge clock); #1;
    chk("b_neg2", neg_b, 32'h3000_0001);
    chk("b_pos2", pos_b, 32'h0000_0009);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
